ssp_rx_drain_ctrl: RTL

Receive-side drain controller for the SSP receive FIFO. It watches the FIFO full interrupt (SSPRXINTR) and, when automatic draining is enabled, issues four back-to-back read strobes, packs the four returned bytes into a 32-bit word and hands the word downstream on a valid/ready handshake. It also shares the FIFO read port with a host APB requester, granting the host access only while no drain burst is in progress.

---
 rtl/ssp_rx_drain_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ssp_rx_drain_ctrl.sv
// ssp_rx_drain_ctrl
// Receive-side drain controller for the 4-deep SSP receive FIFO. On a full
// indication it issues four read strobes, packs the returned bytes into a
// 32-bit word and offers it downstream on valid/ready. The FIFO read port is
// shared with a host requester, which is only granted while the controller
// is idle and not starting a burst.
module ssp_rx_drain_ctrl (
    input  logic        PCLK,
    input  logic        CLEAR,
    input  logic        auto_en,
    input  logic        SSPRXINTR,
    input  logic [7:0]  PRDATA,
    output logic        fifo_psel,
    output logic        fifo_pwrite,
    output logic        fifo_clear_b,
    input  logic        host_psel,
    input  logic        host_pwrite,
    output logic        host_pready,
    output logic [7:0]  host_prdata,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [15:0] drained_words
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        LAST = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [1:0]  cnt_reg;
    logic [1:0]  cnt_next;
    logic [15:0] drained_reg;
    logic        start;
    logic        host_own;
    logic        accept;

    // A burst starts from IDLE on a full FIFO with auto drain enabled; the
    // host only owns the bus in IDLE cycles that are not starting a burst.
    assign start    = (state_reg == IDLE) && auto_en && SSPRXINTR;
    assign host_own = (state_reg == IDLE) && !start && !CLEAR;
    assign accept   = (state_reg == OUT) && word_ready;

    assign fifo_clear_b  = ~CLEAR;
    assign host_prdata   = PRDATA;
    assign word_valid    = (state_reg == OUT);
    assign drained_words = drained_reg;

    // State and strobe counter register
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: four strobes in RD, one capture cycle in LAST, then
    // hold the word in OUT until it is accepted
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = 2'd0;
                if (start) begin
                    state_next = RD;
                end
            end
            RD: begin
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == 2'd3) begin
                    state_next = LAST;
                end
            end
            LAST: begin
                cnt_next   = 2'd0;
                state_next = OUT;
            end
            OUT: begin
                cnt_next = 2'd0;
                if (word_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 2'd0;
            end
        endcase
    end

    // FIFO port mux: controller strobes during RD, host passthrough while it
    // owns the bus, otherwise quiet; everything is blocked while CLEAR is high
    always_comb begin
        fifo_psel   = 1'b0;
        fifo_pwrite = 1'b0;
        host_pready = 1'b0;
        if (!CLEAR) begin
            if (state_reg == RD) begin
                fifo_psel = 1'b1;
            end else if (host_own) begin
                fifo_psel   = host_psel;
                fifo_pwrite = host_pwrite;
                host_pready = 1'b1;
            end
        end
    end

    // Byte lanes: PRDATA lags its strobe by one cycle, so lane k is loaded
    // in RD with cnt = k+1, and the last lane in LAST
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : lane_g
            logic [7:0] lane_reg;
            logic       cap;

            if (gi == 3) begin : last_lane_g
                assign cap = (state_reg == LAST);
            end else begin : rd_lane_g
                assign cap = (state_reg == RD) && (cnt_reg == 2'(gi + 1));
            end

            // Capture this lane's byte from the FIFO read data
            always_ff @(posedge PCLK) begin
                if (CLEAR) begin
                    lane_reg <= 8'd0;
                end else if (cap) begin
                    lane_reg <= PRDATA;
                end
            end

            assign word_data[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    // Count words accepted downstream; wraps at 16 bits
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            drained_reg <= 16'd0;
        end else if (accept) begin
            drained_reg <= drained_reg + 16'd1;
        end
    end

endmodule
